fetch_sequencer: RTL and testbench

- Control unit that owns the PC and sequences the fetch stage of the 16-bit-instruction RISC pipeline.
- Selects the next PC from four sources: the boot vector, sequential increment, the jump target and the interrupt vector.
- Merges two-word instructions (opcode word plus immediate word) into one issue.
- Runs the interrupt entry sequence: bubbles, saved PC, vector load.
- Instruction memory is word-addressed and combinational: `instr_word` is valid in the same cycle as `imem_addr`.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_int_ctrl.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, PC/word types, NOP encoding.
package fetch_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StFetchImm,
        StIntBubble,
        StIntVector
    } fetch_state_e;

    typedef logic [31:0] pc_t;
    typedef logic [15:0] word_t;

    localparam word_t NopWord = 16'h0000;

endpackage

// File: rtl/fetch_int_ctrl.sv
// Interrupt bookkeeping for the fetch sequencer: pending flag, bubble counter and return address.
module fetch_int_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned INT_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt_bit,
    input  logic        take,
    input  logic        bubble_step,
    input  logic        redirect,
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    output logic        pending,
    output logic        bubble_last,
    output logic [31:0] saved_pc
);

    localparam logic [2:0] BubbleInit = 3'(INT_BUBBLES);

    logic       pending_q, pending_d;
    logic [2:0] cnt_q, cnt_d;
    pc_t        saved_q, saved_d;

    always_comb begin
        // The request being taken is consumed; later pulses re-arm for after the return.
        pending_d = take ? 1'b0 : (pending_q | interrupt_bit);

        cnt_d = cnt_q;
        if (take) begin
            cnt_d = BubbleInit;
        end else if (bubble_step) begin
            cnt_d = cnt_q - 3'd1;
        end

        saved_d = saved_q;
        if (take) begin
            saved_d = pc;
        end else if (redirect) begin
            saved_d = branch_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            cnt_q     <= 3'd0;
            saved_q   <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            saved_q   <= saved_d;
        end
    end

    assign pending     = pending_q;
    assign bubble_last = (cnt_q == 3'd1);
    assign saved_pc    = saved_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch-stage sequencer: two-word merge, jumps, interrupt entry.
// Optional FETCH_PERF_CNT_EN adds saturating issue/stall counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned IMM_BIT     = 0,
    parameter int unsigned INT_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] init_pc,
    input  logic        stall,
    input  logic        jump_bit,
    input  logic [31:0] branch_target,
    input  logic        interrupt_bit,
    input  logic [31:0] int_vector,
    input  logic [15:0] instr_word,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [15:0] instruction,
    output logic [15:0] immediate,
    output logic        has_imm,
    output logic [31:0] same_pc,
    output logic [31:0] next_pc,
    output logic        insert_nop,
    output logic        int_ack,
    output logic [31:0] saved_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stalls
`endif
);

    fetch_state_e state_q, state_d;
    pc_t          pc_q, pc_d, op_pc_q, op_pc_d;
    word_t        op_q, op_d;
    logic         pending, bubble_last, take, bubble_step, redirect, pend_eff;

    assign pend_eff  = pending | interrupt_bit;
    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        op_d        = op_q;
        op_pc_d     = op_pc_q;
        instr_valid = 1'b0;
        instruction = NopWord;
        immediate   = 16'h0000;
        has_imm     = 1'b0;
        same_pc     = '0;
        next_pc     = '0;
        insert_nop  = 1'b0;
        int_ack     = 1'b0;
        take        = 1'b0;
        bubble_step = 1'b0;
        redirect    = 1'b0;

        unique case (state_q)
            StBoot: begin
                if (!stall) begin
                    pc_d    = init_pc;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (jump_bit) begin
                    pc_d = branch_target;
                end else if (!stall) begin
                    if (pend_eff) begin
                        take    = 1'b1;
                        state_d = StIntBubble;
                    end else if (instr_word[IMM_BIT]) begin
                        op_d    = instr_word;
                        op_pc_d = pc_q;
                        pc_d    = pc_q + 32'd1;
                        state_d = StFetchImm;
                    end else begin
                        instr_valid = 1'b1;
                        instruction = instr_word;
                        same_pc     = pc_q;
                        next_pc     = pc_q + 32'd1;
                        pc_d        = pc_q + 32'd1;
                    end
                end
            end
            StFetchImm: begin
                if (jump_bit) begin
                    pc_d    = branch_target;
                    state_d = StFetch;
                end else if (!stall) begin
                    instr_valid = 1'b1;
                    instruction = op_q;
                    immediate   = instr_word;
                    has_imm     = 1'b1;
                    same_pc     = op_pc_q;
                    next_pc     = op_pc_q + 32'd2;
                    pc_d        = pc_q + 32'd1;
                    state_d     = StFetch;
                end
            end
            StIntBubble: begin
                // A jump outranks stall, so the bubble still counts down while redirecting.
                if (jump_bit || !stall) begin
                    insert_nop  = 1'b1;
                    bubble_step = 1'b1;
                    if (bubble_last) begin
                        state_d = StIntVector;
                    end
                end
                if (jump_bit) begin
                    pc_d     = branch_target;
                    redirect = 1'b1;
                end
            end
            StIntVector: begin
                // A jump here only retargets the return address; the vector load wins.
                if (jump_bit || !stall) begin
                    pc_d    = int_vector;
                    int_ack = 1'b1;
                    state_d = StFetch;
                end
                redirect = jump_bit;
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            op_q    <= NopWord;
            op_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            op_pc_q <= op_pc_d;
        end
    end

    fetch_int_ctrl #(
        .INT_BUBBLES(INT_BUBBLES)
    ) u_int_ctrl (
        .clk          (clk),
        .rst          (rst),
        .interrupt_bit(interrupt_bit),
        .take         (take),
        .bubble_step  (bubble_step),
        .redirect     (redirect),
        .pc           (pc_q),
        .branch_target(branch_target),
        .pending      (pending),
        .bubble_last  (bubble_last),
        .saved_pc     (saved_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_q, stalls_q;
    logic        stalled;

    // Jump overrides stall everywhere except BOOT, where the jump is ignored.
    assign stalled = stall && !(jump_bit && (state_q != StBoot));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            if (instr_valid && (issued_q != '1)) begin
                issued_q <= issued_q + 32'd1;
            end
            if (stalled && (stalls_q != '1)) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign perf_issued = issued_q;
    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, two-word merge, jumps, interrupts, stall, wrap, reset abort.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] init_pc = 32'h0;
    logic        stall = 1'b0;
    logic        jump_bit = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        interrupt_bit = 1'b0;
    logic [31:0] int_vector = 32'h0;
    logic [15:0] instr_word;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic        has_imm;
    logic [31:0] same_pc;
    logic [31:0] next_pc;
    logic        insert_nop;
    logic        int_ack;
    logic [31:0] saved_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stalls;
`endif

    logic [15:0] mem [0:255];
    int          n_checks = 0;
    int          n_bad = 0;

    assign instr_word = mem[imem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .init_pc      (init_pc),
        .stall        (stall),
        .jump_bit     (jump_bit),
        .branch_target(branch_target),
        .interrupt_bit(interrupt_bit),
        .int_vector   (int_vector),
        .instr_word   (instr_word),
        .imem_addr    (imem_addr),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .immediate    (immediate),
        .has_imm      (has_imm),
        .same_pc      (same_pc),
        .next_pc      (next_pc),
        .insert_nop   (insert_nop),
        .int_ack      (int_ack),
        .saved_pc     (saved_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_issued  (perf_issued),
        .perf_stalls  (perf_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs set after this settle before the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h3810;
        mem[8'h11] = 16'h0005;
        mem[8'h20] = 16'h3811;
        mem[8'h21] = 16'h0004;
        mem[8'h22] = 16'h3811;
        mem[8'h23] = 16'h0007;
        mem[8'h40] = 16'h2200;
        mem[8'h00] = 16'h1234;
        mem[8'hFF] = 16'h0A0A;
        init_pc    = 32'h10;

        // Reset state
        step(); step();
        #1;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_nop", {31'b0, insert_nop}, 32'h0);
        check("rst_ack", {31'b0, int_ack}, 32'h0);
        check("rst_saved", saved_pc, 32'h0);
        check("rst_instr", {16'h0, instruction}, 32'h0);

        // 1. Boot: BOOT cycle issues nothing, then 0x10 issues as a single word
        step(); rst = 1'b0; #1;
        check("boot_noissue", {31'b0, instr_valid}, 32'h0);
        step(); #1;
        check("boot_addr", imem_addr, 32'h10);
        check("boot_valid", {31'b0, instr_valid}, 32'h1);
        check("boot_instr", {16'h0, instruction}, 32'h3810);
        check("boot_same", same_pc, 32'h10);
        check("boot_next", next_pc, 32'h11);
        check("boot_noimm", {31'b0, has_imm}, 32'h0);

        // 2. Two-word instruction at 0x20
        step(); jump_bit = 1'b1; branch_target = 32'h20; #1;
        check("jmp_discard", {31'b0, instr_valid}, 32'h0);
        step(); jump_bit = 1'b0; #1;
        check("two_first_noissue", {31'b0, instr_valid}, 32'h0);
        step(); #1;
        check("two_valid", {31'b0, instr_valid}, 32'h1);
        check("two_has_imm", {31'b0, has_imm}, 32'h1);
        check("two_instr", {16'h0, instruction}, 32'h3811);
        check("two_imm", {16'h0, immediate}, 32'h0004);
        check("two_same", same_pc, 32'h20);
        check("two_next", next_pc, 32'h22);

        // 3. Jump during FETCH_IMM drops the partial instruction
        step(); #1;
        check("j3_first_noissue", {31'b0, instr_valid}, 32'h0);
        step(); jump_bit = 1'b1; branch_target = 32'h40; #1;
        check("j3_dropped", {31'b0, instr_valid}, 32'h0);
        check("j3_no_imm", {31'b0, has_imm}, 32'h0);
        step(); jump_bit = 1'b0; #1;
        check("j3_addr", imem_addr, 32'h40);
        check("j3_instr", {16'h0, instruction}, 32'h2200);
        check("j3_valid", {31'b0, instr_valid}, 32'h1);

        // 4. Interrupt at PC 0x30
        step(); jump_bit = 1'b1; branch_target = 32'h30; #1;
        step(); jump_bit = 1'b0; interrupt_bit = 1'b1; int_vector = 32'h100; #1;
        check("i4_take_noissue", {31'b0, instr_valid}, 32'h0);
        check("i4_take_nonop", {31'b0, insert_nop}, 32'h0);
        step(); interrupt_bit = 1'b0; #1;
        check("i4_saved", saved_pc, 32'h30);
        check("i4_nop1", {31'b0, insert_nop}, 32'h1);
        check("i4_nop1_valid", {31'b0, instr_valid}, 32'h0);
        step(); #1;
        check("i4_nop2", {31'b0, insert_nop}, 32'h1);
        check("i4_ack_early", {31'b0, int_ack}, 32'h0);
        step(); #1;
        check("i4_ack", {31'b0, int_ack}, 32'h1);
        check("i4_nop_end", {31'b0, insert_nop}, 32'h0);
        step(); #1;
        check("i4_vec_addr", imem_addr, 32'h100);
        check("i4_ack_pulse", {31'b0, int_ack}, 32'h0);
        check("i4_vec_instr", {16'h0, instruction}, 32'h1234);
        check("i4_vec_valid", {31'b0, instr_valid}, 32'h1);

        // 5. Stall 3 cycles with an interrupt pulse during the stall
        step(); stall = 1'b1; interrupt_bit = 1'b1; #1;
        check("s5_valid0", {31'b0, instr_valid}, 32'h0);
        check("s5_addr0", imem_addr, 32'h101);
        step(); interrupt_bit = 1'b0; #1;
        check("s5_valid1", {31'b0, instr_valid}, 32'h0);
        check("s5_addr1", imem_addr, 32'h101);
        step(); #1;
        check("s5_valid2", {31'b0, instr_valid}, 32'h0);
        check("s5_addr2", imem_addr, 32'h101);
        step(); stall = 1'b0; #1;
        check("s5_take_noissue", {31'b0, instr_valid}, 32'h0);
        step(); #1;
        check("s5_saved", saved_pc, 32'h101);
        check("s5_nop", {31'b0, insert_nop}, 32'h1);
        step(); #1;
        step(); #1;
        check("s5_ack", {31'b0, int_ack}, 32'h1);
        step(); #1;
        check("s5_vec_addr", imem_addr, 32'h100);
        check("s5_no_refire", {31'b0, instr_valid}, 32'h1);

        // 6. PC wrap
        step(); jump_bit = 1'b1; branch_target = 32'hFFFF_FFFF; #1;
        step(); jump_bit = 1'b0; #1;
        check("w6_valid", {31'b0, instr_valid}, 32'h1);
        check("w6_same", same_pc, 32'hFFFF_FFFF);
        check("w6_next", next_pc, 32'h0);
        check("w6_instr", {16'h0, instruction}, 32'h0A0A);
        step(); #1;
        check("w6_addr", imem_addr, 32'h0);

        // Reset in the middle of FETCH_IMM aborts it and reboots from init_pc
        step(); jump_bit = 1'b1; branch_target = 32'h20; #1;
        step(); jump_bit = 1'b0; #1;
        step(); rst = 1'b1; #1;
        check("r7_addr", imem_addr, 32'h0);
        check("r7_noimm", {31'b0, has_imm}, 32'h0);
        check("r7_novalid", {31'b0, instr_valid}, 32'h0);
        step(); rst = 1'b0; #1;
        step(); #1;
        check("r7_boot_addr", imem_addr, 32'h10);
        check("r7_boot_instr", {16'h0, instruction}, 32'h3810);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
